// File: rtl/motor_pkg.sv
// Shared encodings for the motor peripheral: H-bridge command codes, the gate-drive
// state type and the default dead-time.
package motor_pkg;

  localparam logic [1:0] CMD_COAST = 2'b00;
  localparam logic [1:0] CMD_FWD   = 2'b01;
  localparam logic [1:0] CMD_REV   = 2'b10;
  localparam logic [1:0] CMD_BRAKE = 2'b11;

  localparam int unsigned DEADTIME_CC_DEFAULT = 50;

  typedef enum logic [2:0] {
    StCoast,
    StFwd,
    StRev,
    StBrake,
    StDead,
    StFaulted
  } state_e;

  function automatic state_e cmd_to_state(input logic [1:0] cmd);
    state_e s;
    s = StCoast;
    case (cmd)
      CMD_FWD:   s = StFwd;
      CMD_REV:   s = StRev;
      CMD_BRAKE: s = StBrake;
      default:   s = StCoast;
    endcase
    return s;
  endfunction

  function automatic logic [1:0] state_to_cmd(input state_e s);
    logic [1:0] c;
    c = CMD_COAST;
    case (s)
      StFwd:   c = CMD_FWD;
      StRev:   c = CMD_REV;
      StBrake: c = CMD_BRAKE;
      default: c = CMD_COAST;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hbridge_gate_drive_if.sv
// Command/PWM/fault inputs and bridge/status outputs of the H-bridge gate driver.
interface hbridge_gate_drive_if;

  logic [1:0] HBRIDGE_CMD;
  logic       PWM_IN;
  logic       FAULT_N;
  logic       FAULT_CLR;
  logic       DRV_A;
  logic       DRV_B;
  logic       FAULT;
  logic       BUSY;

  modport master (
    output HBRIDGE_CMD, PWM_IN, FAULT_N, FAULT_CLR,
    input  DRV_A, DRV_B, FAULT, BUSY
  );

  modport slave (
    input  HBRIDGE_CMD, PWM_IN, FAULT_N, FAULT_CLR,
    output DRV_A, DRV_B, FAULT, BUSY
  );

endinterface

// File: rtl/sync_ff.sv
// N-flop synchroniser for an asynchronous level; flops reset to 1 (inactive for
// active-low pins).
module sync_ff #(
    parameter int unsigned N = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[N-2:0], d_i};
        end
    end

    assign q_o = sync_q[N-1];

endmodule

// File: rtl/hbridge_gate_drive.sv
// H-bridge gate driver: maps mode commands and PWM onto the two bridge pins, inserting
// dead-time between driven modes and latching the external driver fault.
module hbridge_gate_drive
    import motor_pkg::*;
#(
    parameter int unsigned DEADTIME_CC = DEADTIME_CC_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic                 PCLK,
    input logic                 PRESERN,
    hbridge_gate_drive_if.slave bus
);

    localparam int unsigned     CntW    = $clog2(DEADTIME_CC + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(DEADTIME_CC - 1);

    state_e          state_q, state_d;
    logic [1:0]      target_q, target_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            drv_a_q, drv_a_d;
    logic            drv_b_q, drv_b_d;
    logic            fault_q, fault_d;
    logic            busy_q, busy_d;
    logic            fault_n_sync;

    sync_ff #(
        .N(SYNC_STAGES)
    ) u_fault_sync (
        .clk_i (PCLK),
        .rst_ni(PRESERN),
        .d_i   (bus.FAULT_N),
        .q_o   (fault_n_sync)
    );

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        // A synced fault beats every other transition, including a running dead-time.
        if (!fault_n_sync) begin
            state_d = StFaulted;
        end else begin
            unique case (state_q)
                StCoast: begin
                    if (bus.HBRIDGE_CMD != CMD_COAST) state_d = cmd_to_state(bus.HBRIDGE_CMD);
                end
                StFwd, StRev, StBrake: begin
                    if (bus.HBRIDGE_CMD != state_to_cmd(state_q)) begin
                        state_d  = StDead;
                        target_d = bus.HBRIDGE_CMD;
                        cnt_d    = CntLoad;
                    end
                end
                StDead: begin
                    // A changed request restarts the full dead-time rather than shortening it.
                    if (bus.HBRIDGE_CMD != target_q) begin
                        target_d = bus.HBRIDGE_CMD;
                        cnt_d    = CntLoad;
                    end else if (cnt_q == '0) begin
                        state_d = cmd_to_state(target_q);
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                StFaulted: begin
                    if (bus.FAULT_CLR) begin
                        state_d  = StDead;
                        target_d = bus.HBRIDGE_CMD;
                        cnt_d    = CntLoad;
                    end
                end
                default: state_d = StCoast;
            endcase
        end
    end

    // Pins are decoded from the next state so they land one cycle after the inputs.
    always_comb begin
        drv_a_d = 1'b0;
        drv_b_d = 1'b0;
        fault_d = 1'b0;
        busy_d  = 1'b0;
        unique case (state_d)
            StFwd:     drv_a_d = bus.PWM_IN;
            StRev:     drv_b_d = bus.PWM_IN;
            StBrake: begin
                drv_a_d = 1'b1;
                drv_b_d = 1'b1;
            end
            StDead:    busy_d  = 1'b1;
            StFaulted: fault_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            state_q  <= StCoast;
            target_q <= CMD_COAST;
            cnt_q    <= '0;
            drv_a_q  <= 1'b0;
            drv_b_q  <= 1'b0;
            fault_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            drv_a_q  <= drv_a_d;
            drv_b_q  <= drv_b_d;
            fault_q  <= fault_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.DRV_A = drv_a_q;
    assign bus.DRV_B = drv_b_q;
    assign bus.FAULT = fault_q;
    assign bus.BUSY  = busy_q;

endmodule

// File: tb/tb_hbridge_gate_drive.sv
// Directed bench for hbridge_gate_drive: each stimulus cycle queues its hand-computed
// {DRV_A, DRV_B, FAULT, BUSY}; a monitor pops and compares after every clock/reset edge.
module tb_hbridge_gate_drive;
    import motor_pkg::*;

    logic PCLK;
    logic PRESERN;

    hbridge_gate_drive_if bus ();

    hbridge_gate_drive #(
        .DEADTIME_CC(4),
        .SYNC_STAGES(2)
    ) dut (
        .PCLK   (PCLK),
        .PRESERN(PRESERN),
        .bus    (bus)
    );

    typedef struct {
        logic [3:0] exp;
        string      name;
    } exp_t;

    exp_t  sb[$];
    int    total = 0;
    int    bad = 0;
    string phase = "reset";

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    // Monitor: outputs are registered (or async-cleared), so sample 1 time unit after
    // each rising clock or falling reset edge.
    initial begin
        exp_t       e;
        logic [3:0] act;
        forever begin
            @(posedge PCLK or negedge PRESERN);
            #1;
            if (sb.size() != 0) begin
                e   = sb.pop_front();
                act = {bus.DRV_A, bus.DRV_B, bus.FAULT, bus.BUSY};
                total++;
                if (act !== e.exp) begin
                    bad++;
                    $display("FAIL %s @%0t: a/b/fault/busy got=%b want=%b", e.name, $time, act,
                             e.exp);
                end
            end
        end
    end

    task automatic cyc(input logic rstn, input logic [1:0] cmd, input logic pwm,
                       input logic fn, input logic clr, input logic [3:0] exp);
        @(negedge PCLK);
        PRESERN         = rstn;
        bus.HBRIDGE_CMD = cmd;
        bus.PWM_IN      = pwm;
        bus.FAULT_N     = fn;
        bus.FAULT_CLR   = clr;
        sb.push_back('{exp: exp, name: phase});
    endtask

    task automatic async_reset();
        @(negedge PCLK);
        #2;
        sb.push_back('{exp: 4'b0000, name: "async_reset"});
        PRESERN = 1'b0;
    endtask

    initial begin
        logic p;
        PRESERN         = 1'b0;
        bus.HBRIDGE_CMD = CMD_COAST;
        bus.PWM_IN      = 1'b0;
        bus.FAULT_N     = 1'b1;
        bus.FAULT_CLR   = 1'b0;

        phase = "reset";
        repeat (2) cyc(1'b0, CMD_FWD, 1'b1, 1'b1, 1'b0, 4'b0000);

        // Leaving COAST needs no dead-time; DRV_A tracks PWM one cycle later.
        phase = "fwd_pwm";
        for (int i = 0; i < 9; i++) begin
            p = ((i / 3) % 2) == 0;
            cyc(1'b1, CMD_FWD, p, 1'b1, 1'b0, {p, 3'b000});
        end

        phase = "fwd_to_rev";
        repeat (4) cyc(1'b1, CMD_REV, 1'b1, 1'b1, 1'b0, 4'b0001);
        cyc(1'b1, CMD_REV, 1'b1, 1'b1, 1'b0, 4'b0100);
        cyc(1'b1, CMD_REV, 1'b0, 1'b1, 1'b0, 4'b0000);
        cyc(1'b1, CMD_REV, 1'b1, 1'b1, 1'b0, 4'b0100);

        phase = "rev_to_brake";
        repeat (4) cyc(1'b1, CMD_BRAKE, 1'b1, 1'b1, 1'b0, 4'b0001);
        repeat (2) cyc(1'b1, CMD_BRAKE, 1'b0, 1'b1, 1'b0, 4'b1100);

        phase = "brake_to_coast";
        repeat (4) cyc(1'b1, CMD_COAST, 1'b1, 1'b1, 1'b0, 4'b0001);
        repeat (2) cyc(1'b1, CMD_COAST, 1'b1, 1'b1, 1'b0, 4'b0000);

        // BRAKE arrives on the 3rd dead cycle: full restart, REV never shows.
        phase = "dead_restart";
        cyc(1'b1, CMD_FWD, 1'b1, 1'b1, 1'b0, 4'b1000);
        repeat (2) cyc(1'b1, CMD_REV, 1'b1, 1'b1, 1'b0, 4'b0001);
        repeat (4) cyc(1'b1, CMD_BRAKE, 1'b1, 1'b1, 1'b0, 4'b0001);
        cyc(1'b1, CMD_BRAKE, 1'b1, 1'b1, 1'b0, 4'b1100);

        phase = "brake_to_fwd";
        repeat (4) cyc(1'b1, CMD_FWD, 1'b1, 1'b1, 1'b0, 4'b0001);
        cyc(1'b1, CMD_FWD, 1'b1, 1'b1, 1'b0, 4'b1000);

        // One-cycle FAULT_N pulse reaches the FSM after two sync flops.
        phase = "fault_entry";
        cyc(1'b1, CMD_FWD, 1'b1, 1'b0, 1'b0, 4'b1000);
        cyc(1'b1, CMD_FWD, 1'b1, 1'b1, 1'b0, 4'b1000);
        cyc(1'b1, CMD_FWD, 1'b1, 1'b1, 1'b0, 4'b0010);
        cyc(1'b1, CMD_FWD, 1'b1, 1'b1, 1'b0, 4'b0010);

        phase = "fault_clr_ignored";
        repeat (2) cyc(1'b1, CMD_FWD, 1'b1, 1'b0, 1'b0, 4'b0010);
        cyc(1'b1, CMD_FWD, 1'b1, 1'b0, 1'b1, 4'b0010);
        // Pin already high but the synchronised copy is still low.
        cyc(1'b1, CMD_FWD, 1'b1, 1'b1, 1'b1, 4'b0010);
        cyc(1'b1, CMD_FWD, 1'b1, 1'b1, 1'b0, 4'b0010);
        cyc(1'b1, CMD_FWD, 1'b1, 1'b1, 1'b0, 4'b0010);

        phase = "fault_clr";
        cyc(1'b1, CMD_FWD, 1'b1, 1'b1, 1'b1, 4'b0001);
        repeat (3) cyc(1'b1, CMD_FWD, 1'b1, 1'b1, 1'b0, 4'b0001);
        cyc(1'b1, CMD_FWD, 1'b1, 1'b1, 1'b0, 4'b1000);

        phase = "reset_mid_dead";
        repeat (2) cyc(1'b1, CMD_REV, 1'b1, 1'b1, 1'b0, 4'b0001);
        async_reset();
        repeat (2) cyc(1'b0, CMD_REV, 1'b1, 1'b1, 1'b0, 4'b0000);

        phase = "rev_after_reset";
        cyc(1'b1, CMD_REV, 1'b1, 1'b1, 1'b0, 4'b0100);
        cyc(1'b1, CMD_REV, 1'b0, 1'b1, 1'b0, 4'b0000);
        cyc(1'b1, CMD_REV, 1'b1, 1'b1, 1'b0, 4'b0100);

        @(posedge PCLK);
        #3;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: pending expectations got=%0d want=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
